// File: rtl/demux_stream.sv
// demux_stream: routes one input stream to N_CH output channels, each holding a
// one-entry output register (EMPTY/FULL) with pass-through refill.
//
// Optional feature: define DEMUX_BCAST_EN to compile in broadcast mode
// (in_bcast port; a broadcast word loads every channel in the same edge).
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word present
//   in_ready   block accepts the word this cycle (0 while in reset)
//   in_data    payload, DATA_W bits
//   in_sel     destination channel index, SEL_W bits
//   in_bcast   broadcast request (DEMUX_BCAST_EN only)
//   out_valid  per-channel word present
//   out_ready  per-channel consumer accept
//   out_data   channel k occupies bits [k*DATA_W +: DATA_W]
//   err_cnt    saturating count of dropped out-of-range words
module demux_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic                     in_bcast,
`endif
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [7:0]               err_cnt
);

  typedef enum logic {StEmpty, StFull} ch_state_e;

  ch_state_e         state_q [N_CH];
  ch_state_e         state_d [N_CH];
  logic [DATA_W-1:0] data_q  [N_CH];
  logic [N_CH-1:0]   can_acc;
  logic [N_CH-1:0]   load;
  logic              in_range;
  logic              sel_acc;
  logic              route_rdy;
  logic              rdy_raw;
  logic              xfer;
  logic              err_inc;
  logic [7:0]        err_q;
  logic [7:0]        err_d;

  // A channel can take a word when empty, or when full and draining this cycle.
  always_comb begin
    can_acc = '0;
    for (int k = 0; k < N_CH; k++) begin
      can_acc[k] = (state_q[k] == StEmpty) | out_ready[k];
    end
  end

  assign in_range = 32'(in_sel) < N_CH;

  // Explicit compare loop avoids indexing can_acc with an out-of-range select.
  always_comb begin
    sel_acc = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_acc = can_acc[k];
      end
    end
  end

  // Out-of-range words are always accepted (and dropped).
  assign route_rdy = in_range ? sel_acc : 1'b1;

`ifdef DEMUX_BCAST_EN
  assign rdy_raw = in_bcast ? (&can_acc) : route_rdy;
`else
  assign rdy_raw = route_rdy;
`endif

  assign in_ready = rst_n & rdy_raw;
  assign xfer     = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = xfer & in_range & (in_sel == SEL_W'(k));
`ifdef DEMUX_BCAST_EN
      if (in_bcast) begin
        load[k] = xfer;
      end
`endif
    end
  end

`ifdef DEMUX_BCAST_EN
  assign err_inc = xfer & ~in_range & ~in_bcast;
`else
  assign err_inc = xfer & ~in_range;
`endif

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // Per-channel EMPTY/FULL next state; a load while draining stays FULL.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        StEmpty: if (load[k]) state_d[k] = StFull;
        StFull:  if (out_ready[k] && !load[k]) state_d[k] = StEmpty;
        default: state_d[k] = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= StEmpty;
        data_q[k]  <= '0;
      end
      err_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        if (load[k]) begin
          data_q[k] <= in_data;
        end
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      out_valid[k]                  = (state_q[k] == StFull);
      out_data[k*DATA_W +: DATA_W]  = data_q[k];
    end
  end

  assign err_cnt = err_q;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: two instances (4 channels, and 3 channels with a 2-bit
// select so index 3 is out of range), directed literal checks plus random traffic
// compared every cycle against a queue-level channel model.
module tb_demux_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv   [2];
  logic [7:0] id   [2];
  logic [1:0] isel [2];
  logic [3:0] ordy [2];
  logic       rdy  [2];
`ifdef DEMUX_BCAST_EN
  logic       ib   [2];
`endif
  logic [3:0]  ov_a;
  logic [2:0]  ov_b;
  logic [31:0] od_a;
  logic [23:0] od_b;
  logic [7:0]  err_a;
  logic [7:0]  err_b;

  int n_tests = 0;
  int n_fail  = 0;

  demux_stream #(.DATA_W(8), .N_CH(4), .SEL_W(2)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[0]),
    .in_ready  (rdy[0]),
    .in_data   (id[0]),
    .in_sel    (isel[0]),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (ib[0]),
`endif
    .out_valid (ov_a),
    .out_ready (ordy[0]),
    .out_data  (od_a),
    .err_cnt   (err_a)
  );

  demux_stream #(.DATA_W(8), .N_CH(3), .SEL_W(2)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[1]),
    .in_ready  (rdy[1]),
    .in_data   (id[1]),
    .in_sel    (isel[1]),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (ib[1]),
`endif
    .out_valid (ov_b),
    .out_ready (ordy[1][2:0]),
    .out_data  (od_b),
    .err_cnt   (err_b)
  );

  // ---------------- behavioural model ----------------
  bit         mfull [2][4];
  logic [7:0] mdata [2][4];
  int         merr  [2];

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic bit can(input int d, input int k);
    return !mfull[d][k] || (ordy[d][k] == 1'b1);
  endfunction

  function automatic bit rdy_exp(input int d);
    bit all_ok;
    if (!rst_n) return 1'b0;
`ifdef DEMUX_BCAST_EN
    if (ib[d]) begin
      all_ok = 1'b1;
      for (int k = 0; k < nch(d); k++) if (!can(d, k)) all_ok = 1'b0;
      return all_ok;
    end
`endif
    if (int'(isel[d]) >= nch(d)) return 1'b1;
    return can(d, int'(isel[d]));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          mfull[d][k] <= 1'b0;
          mdata[d][k] <= 8'h00;
        end
        merr[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < nch(d); k++) begin
          if (mfull[d][k] && ordy[d][k]) mfull[d][k] <= 1'b0;
        end
        if (iv[d] && rdy_exp(d)) begin
`ifdef DEMUX_BCAST_EN
          if (ib[d]) begin
            for (int k = 0; k < nch(d); k++) begin
              mfull[d][k] <= 1'b1;
              mdata[d][k] <= id[d];
            end
          end else
`endif
          if (int'(isel[d]) < nch(d)) begin
            mfull[d][isel[d]] <= 1'b1;
            mdata[d][isel[d]] <= id[d];
          end else if (merr[d] < 255) begin
            merr[d] <= merr[d] + 1;
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic ov(input int d, input int k);
    if (d == 0) return ov_a[k];
    return ov_b[k];
  endfunction

  function automatic logic [7:0] od(input int d, input int k);
    if (d == 0) return od_a[k*8 +: 8];
    return od_b[k*8 +: 8];
  endfunction

  function automatic logic [7:0] errv(input int d);
    return (d == 0) ? err_a : err_b;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("in_ready", d, 32'(rdy[d]), 32'(rdy_exp(d)));
      for (int k = 0; k < nch(d); k++) begin
        chk("out_valid", d, 32'(ov(d, k)), 32'(mfull[d][k]));
        chk("out_data", d, 32'(od(d, k)), 32'(mdata[d][k]));
      end
      chk("err_cnt", d, 32'(errv(d)), 32'(merr[d]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus + literal expectations ----------------
  logic [7:0] t33 [4];

  initial begin
    t33[0] = 8'hA1; t33[1] = 8'hB2; t33[2] = 8'hC3; t33[3] = 8'hD4;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; id[d] = 8'h00; isel[d] = 2'd0; ordy[d] = 4'h0;
`ifdef DEMUX_BCAST_EN
      ib[d] = 1'b0;
`endif
    end
    // In reset: in_ready stays low even with an acceptable word offered.
    iv[0] = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", 0, 32'(rdy[0]), 32'd0);
    chk("rst_out_valid", 0, 32'(ov_a), 32'd0);
    chk("rst_err", 1, 32'(err_b), 32'd0);
    iv[0] = 1'b0;
    rst_n = 1'b1;
    tick();

    // Route four words, one per channel, all consumers ready.
    ordy[0] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; isel[0] = 2'(i); id[0] = t33[i];
      #1 chk("route_ready", 0, 32'(rdy[0]), 32'd1);
      tick();
      chk("route_valid", 0, 32'(ov_a), 32'(4'b0001 << i));
      chk("route_data", 0, 32'(od_a[i*8 +: 8]), 32'(t33[i]));
    end
    iv[0] = 1'b0;
    tick();
    chk("route_idle", 0, 32'(ov_a), 32'd0);

    // Backpressure on channel 2.
    ordy[0] = 4'b1011;
    iv[0] = 1'b1; isel[0] = 2'd2; id[0] = 8'h11;
    tick();
    chk("bp_first", 0, 32'(od_a[23:16]), 32'h11);
    id[0] = 8'h22;
    #1 chk("bp_stall", 0, 32'(rdy[0]), 32'd0);
    tick();
    chk("bp_held", 0, 32'(od_a[23:16]), 32'h11);
    chk("bp_held_v", 0, 32'(ov_a[2]), 32'd1);
    ordy[0] = 4'hF;
    #1 chk("bp_release", 0, 32'(rdy[0]), 32'd1);
    tick();
    chk("bp_second", 0, 32'(od_a[23:16]), 32'h22);
    chk("bp_second_v", 0, 32'(ov_a[2]), 32'd1);
    iv[0] = 1'b0;
    tick();
    chk("bp_drained", 0, 32'(ov_a[2]), 32'd0);

    // Independence: channel 1 stalled full, channel 3 still flows.
    ordy[0] = 4'b1101;
    iv[0] = 1'b1; isel[0] = 2'd1; id[0] = 8'h33;
    tick();
    isel[0] = 2'd3; id[0] = 8'h55;
    #1 chk("ind_ready", 0, 32'(rdy[0]), 32'd1);
    tick();
    chk("ind_valid", 0, 32'(ov_a), 32'b1010);
    chk("ind_ch3", 0, 32'(od_a[31:24]), 32'h55);
    chk("ind_ch1", 0, 32'(od_a[15:8]), 32'h33);
    iv[0] = 1'b0; ordy[0] = 4'hF;
    tick();

    // Out-of-range flood on the 3-channel instance.
    ordy[1] = 4'hF;
    iv[1] = 1'b1; isel[1] = 2'd3;
    for (int i = 0; i < 300; i++) begin
      id[1] = 8'($urandom);
      #1 chk("oor_ready", 1, 32'(rdy[1]), 32'd1);
      tick();
      chk("oor_valid", 1, 32'(ov_b), 32'd0);
    end
    iv[1] = 1'b0;
    chk("oor_err_sat", 1, 32'(err_b), 32'd255);

    // Reset mid-operation with channels 0 and 2 full.
    ordy[0] = 4'h0;
    iv[0] = 1'b1; isel[0] = 2'd0; id[0] = 8'h12;
    tick();
    isel[0] = 2'd2; id[0] = 8'h34;
    tick();
    isel[0] = 2'd1; id[0] = 8'h9C;
    #1 rst_n = 1'b0;
    #1 chk("mrst_valid", 0, 32'(ov_a), 32'd0);
    chk("mrst_data", 0, od_a, 32'd0);
    chk("mrst_err", 1, 32'(err_b), 32'd0);
    chk("mrst_ready", 0, 32'(rdy[0]), 32'd0);
    #2 rst_n = 1'b1;
    ordy[0] = 4'hF;
    #1 chk("post_rst_ready", 0, 32'(rdy[0]), 32'd1);
    tick();
    chk("post_rst_valid", 0, 32'(ov_a), 32'b0010);
    chk("post_rst_data", 0, 32'(od_a[15:8]), 32'h9C);
    iv[0] = 1'b0;
    tick();

`ifdef DEMUX_BCAST_EN
    // Broadcast blocked by stalled channel 1, then lands everywhere at once.
    ordy[0] = 4'b1101;
    iv[0] = 1'b1; isel[0] = 2'd1; id[0] = 8'hAA;
    tick();
    ib[0] = 1'b1; id[0] = 8'h7E; isel[0] = 2'd0;
    #1 chk("bc_blocked", 0, 32'(rdy[0]), 32'd0);
    tick();
    chk("bc_hold", 0, 32'(ov_a), 32'b0010);
    ordy[0] = 4'hF;
    #1 chk("bc_ready", 0, 32'(rdy[0]), 32'd1);
    tick();
    chk("bc_valid", 0, 32'(ov_a), 32'hF);
    chk("bc_data", 0, od_a, 32'h7E7E7E7E);
    chk("bc_err", 0, 32'(err_a), 32'd0);
    iv[0] = 1'b0; ib[0] = 1'b0;
    tick();
`endif

    // Random traffic on both instances, checked by the compare process.
    for (int n = 0; n < 2000; n++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]   = ($urandom % 4) != 0;
        isel[d] = 2'($urandom_range(0, 3));
        id[d]   = 8'($urandom);
        ordy[d] = 4'($urandom);
`ifdef DEMUX_BCAST_EN
        ib[d]   = ($urandom % 8) == 0;
`endif
      end
      tick();
    end
    for (int d = 0; d < 2; d++) iv[d] = 1'b0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
